multdiv_wb_scheduler: RTL
=========================

// Module: multdiv_wb_scheduler
// PURPOSE
//  Sequences one in-flight multi-cycle mul/div op and arbitrates the single regfile write
//  port between pipeline writeback and late multdiv results. Sits between the write stage
//  and the regfile; drives ctrl_writeEnable/ctrl_writeReg/data_writeReg.
//  Redirects a multdiv exception to $r30. Exports busy/pending-rd for issue stall and hazard logic.
// PARAMETERS
//  DATA_W    32  regfile data width
//  REG_W     5   register index width
//  EXC_REG   30  exception/status register ($rstatus)
//  EXC_MUL   4   value written to EXC_REG on mul exception
//  EXC_DIV   5   value written to EXC_REG on div exception (div by zero)
//  TIMEOUT   64  max RUN cycles waiting for md_rdy before abort
//  STARVE_MAX 8  HOLD cycles before forced priority (MD_STARVE_GUARD_EN only)
// PORTS
//  clock           in   1      rising-edge clock
//  reset_n         in   1      async active-low reset
//  md_issue        in   1      1-cycle pulse: multdiv op launched
//  md_is_div       in   1      op type at issue (1=div, 0=mul)
//  md_rd           in   REG_W  destination reg at issue
//  md_rdy          in   1      multdiv result valid (1-cycle pulse)
//  md_result       in   DATA_W multdiv result, valid with md_rdy
//  md_exception    in   1      multdiv exception, valid with md_rdy
//  pipe_we         in   1      pipeline writeback request
//  pipe_reg        in   REG_W  pipeline destination reg
//  pipe_data       in   DATA_W pipeline writeback data
//  ctrl_writeEnable out 1      regfile write enable
//  ctrl_writeReg   out  REG_W  regfile write index
//  data_writeReg   out  DATA_W regfile write data
//  md_busy         out  1      state != IDLE; issue must stall further multdiv ops
//  md_pend_valid   out  1      pending multdiv write not squashed
//  md_pend_rd      out  REG_W  pending destination reg
//  md_timeout      out  1      sticky: TIMEOUT expired; cleared only by reset
//  pipe_stall      out  1      pipeline writeback deferred this cycle
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, cnt=0, hold regs=0, squash=0, md_timeout=0;
//   port outputs pass pipe_* through; md_busy=0, md_pend_valid=0, pipe_stall=0.
//  FSM: IDLE, RUN, HOLD.
//  IDLE: md_issue -> capture md_rd, md_is_div; cnt=0; squash=(md_rd==0); -> RUN.
//  md_issue when state!=IDLE: ignored, no state change.
//  RUN: cnt++ each cycle. On md_rdy:
//   - port free (pipe_we=0): write same cycle (0-cycle latency, combinational) -> IDLE.
//   - port busy: latch result/exception into hold regs -> HOLD.
//   - no md_rdy and cnt==TIMEOUT-1: set md_timeout, no write -> IDLE.
//  HOLD: write from hold regs in the first cycle pipe_we=0 -> IDLE.
//  Multdiv write: md_exception ? (EXC_REG, is_div?EXC_DIV:EXC_MUL) : (md_rd, result).
//   Exception write to EXC_REG ignores squash.
//   Non-exception write suppressed (no WE, state still -> IDLE) if squash=1.
//  Pipeline always owns the port when pipe_we=1 (except guard, below).
//  WAW squash: in RUN/HOLD, pipe_we && pipe_reg==md_pend_rd sets squash; younger wins.
//  md_pend_valid = (RUN|HOLD) & ~squash; feeds decode hazard compare.
//  Same-cycle pipe write to the same rd as md_rdy: pipe written, multdiv squashed.
//  md_rdy in IDLE or HOLD: ignored (protocol violation; bench asserts never occurs).
//  Reset mid-op: op lost, no write; the multdiv unit is reset by the same reset_n.
// CONFIGURATION
//  MD_STARVE_GUARD_EN defined:
//   - HOLD counts cycles; at count==STARVE_MAX, held result takes the port.
//   - pipe_stall=1 that cycle; pipe write is not performed; pipeline must hold its state.
//   - Count clears on leaving HOLD.
//  MD_STARVE_GUARD_EN undefined: pipe_stall tied 0; HOLD waits indefinitely for a free port.
// TESTING
//  T1 issue mul rd=3; md_rdy+result=0x2A at cycle 5, pipe_we=0
//     -> WE=1, reg=3, data=0x2A same cycle; busy=0 next cycle.
//  T2 issue div rd=7; md_rdy+0x10 while pipe_we=1 reg=4 for 2 cycles
//     -> reg4 written twice, then reg7=0x10; HOLD lasts 2 cycles.
//  T3 issue div rd=9; md_rdy+md_exception=1
//     -> write reg30=5, reg9 untouched; repeat as mul -> reg30=4.
//  T4 issue mul rd=6; pipe writes reg6=0x1 before rdy
//     -> md_pend_valid=0; on md_rdy no WE; reg6 keeps 0x1.
//  T5 issue, never assert md_rdy -> at RUN cycle 64 md_timeout=1, state IDLE, no write;
//     second issue accepted; md_timeout stays 1 until reset.
//  T6 assert reset_n=0 mid-RUN -> outputs at reset values immediately; no later write.
//     With MD_STARVE_GUARD_EN and pipe_we held 1: held write at HOLD cycle 8, pipe_stall=1.

Source files
------------

// File: rtl/multdiv_wb_scheduler.sv
// -----------------------------------------------------------------------------
// multdiv_wb_scheduler
//
// Tracks the single in-flight multi-cycle mul/div operation and arbitrates the
// one regfile write port between normal pipeline writeback and the late
// multdiv result. Multdiv exceptions are redirected to the status register
// EXC_REG. Busy / pending-destination outputs feed issue stall and decode
// hazard detection.
//
// Optional feature: define MD_STARVE_GUARD_EN to let a held result take the
// port after STARVE_MAX cycles in HOLD, stalling the pipeline writeback for
// that one cycle. Without it pipe_stall is tied low and HOLD waits for a free
// port indefinitely.
//
// Ports
//   clock, reset_n        rising-edge clock, async active-low reset
//   md_issue/_is_div/_rd  op launch pulse, op type and destination register
//   md_rdy/_result/_exc   result-valid pulse with data and exception flag
//   pipe_we/_reg/_data    pipeline writeback request
//   ctrl_writeEnable,
//   ctrl_writeReg,
//   data_writeReg         regfile write port
//   md_busy               op in flight; issue must stall further multdiv ops
//   md_pend_valid/_rd     live (unsquashed) pending multdiv destination
//   md_timeout            sticky: op abandoned after TIMEOUT RUN cycles
//   pipe_stall            pipeline writeback deferred this cycle
// -----------------------------------------------------------------------------
module multdiv_wb_scheduler #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int EXC_REG    = 30,
  parameter int EXC_MUL    = 4,
  parameter int EXC_DIV    = 5,
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              md_issue,
  input  logic              md_is_div,
  input  logic [REG_W-1:0]  md_rd,
  input  logic              md_rdy,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              md_busy,
  output logic              md_pend_valid,
  output logic [REG_W-1:0]  md_pend_rd,
  output logic              md_timeout,
  output logic              pipe_stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [REG_W-1:0]  EXC_IDX  = REG_W'(EXC_REG);
  localparam logic [DATA_W-1:0] MUL_CODE = DATA_W'(EXC_MUL);
  localparam logic [DATA_W-1:0] DIV_CODE = DATA_W'(EXC_DIV);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [REG_W-1:0]  pend_rd;
  logic              pend_div;
  logic              squash;
  logic              hold_exc;
  logic [DATA_W-1:0] hold_result;

  logic              md_wr;        // multdiv result owns the port this cycle
  logic              wr_exc;
  logic [DATA_W-1:0] wr_data;
  logic              latch_hold;
  logic              timeout_hit;
  logic              starve_hit;
  logic              pipe_hits_rd;

`ifdef MD_STARVE_GUARD_EN
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  logic [SCNT_W-1:0] starve_cnt;

  // starve_cnt equals the 1-based HOLD cycle number, so the forced write
  // lands on HOLD cycle STARVE_MAX.
  assign starve_hit = (state == HOLD) && (starve_cnt == SCNT_W'(STARVE_MAX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                starve_cnt <= '0;
    else if (state_nxt != HOLD)  starve_cnt <= '0;
    else if (state != HOLD)      starve_cnt <= SCNT_W'(1);
    else                         starve_cnt <= starve_cnt + SCNT_W'(1);
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign md_busy       = (state != IDLE);
  assign md_pend_valid = md_busy && !squash;
  assign md_pend_rd    = pend_rd;
  // A deferred (stalled) pipe write never reached the regfile, so it must not
  // squash the older multdiv result.
  assign pipe_hits_rd  = pipe_we && !pipe_stall && (pipe_reg == pend_rd);

  // NOTE: every combinational output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt        = state;
    ctrl_writeEnable = pipe_we;
    ctrl_writeReg    = pipe_reg;
    data_writeReg    = pipe_data;
    pipe_stall       = 1'b0;
    md_wr            = 1'b0;
    wr_exc           = 1'b0;
    wr_data          = '0;
    latch_hold       = 1'b0;
    timeout_hit      = 1'b0;

    unique case (state)
      IDLE: if (md_issue) state_nxt = RUN;
      RUN: begin
        if (md_rdy) begin
          if (pipe_we) begin
            latch_hold = 1'b1;
            state_nxt  = HOLD;
          end else begin
            md_wr     = 1'b1;
            wr_exc    = md_exception;
            wr_data   = md_result;
            state_nxt = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      HOLD: begin
        pipe_stall = pipe_we && starve_hit;
        if (!pipe_we || starve_hit) begin
          md_wr     = 1'b1;
          wr_exc    = hold_exc;
          wr_data   = hold_result;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (md_wr) begin
      // Exception status always lands; a squashed data write just vanishes.
      ctrl_writeEnable = wr_exc || !squash;
      ctrl_writeReg    = wr_exc ? EXC_IDX : pend_rd;
      data_writeReg    = wr_exc ? (pend_div ? DIV_CODE : MUL_CODE) : wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the hold data registers are reset too; they are only read in HOLD,
  // but a defined value keeps reset state fully deterministic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_rd     <= '0;
      pend_div    <= 1'b0;
      squash      <= 1'b0;
      hold_exc    <= 1'b0;
      hold_result <= '0;
      md_timeout  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (md_issue) begin
          pend_rd  <= md_rd;
          pend_div <= md_is_div;
          cnt      <= '0;
          squash   <= (md_rd == '0);
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (latch_hold) begin
            hold_result <= md_result;
            hold_exc    <= md_exception;
          end
          if (timeout_hit)  md_timeout <= 1'b1;
          if (pipe_hits_rd) squash     <= 1'b1;
        end
        HOLD: if (pipe_hits_rd) squash <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
